// File: rtl/bus_sequencer.sv
// bus_sequencer
//   Two-cycle FETCH/EXEC control sequencer in front of the register file.
//   FETCH puts the ROM on dbus and latches the instruction byte. EXEC
//   enables one bus source and at most one load strobe, or performs a jump.
//   Byte 8'hFF halts the sequencer until reset.
//
//   Instruction byte: ir[7:6] source (00 A, 01 X, 10 ALU, 11 ROM immediate)
//                     ir[5:3] destination (000 A, 001 B, 010 X, 011 Q,
//                             100 jump, 101 jump if flagZ, 110 out, 111 nop)
//                     ir[2:0] ALU function
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-high; forces every strobe inactive
//   dbus[7:0]     shared data bus (instruction / immediate / jump target)
//   flagZ         ALU zero flag for the conditional jump
//   step          (SEQUENCER_SINGLE_STEP_EN only) releases one fetch
//   pc            ROM address
//   assertBarRom/A/X/Alu   active-low bus driver enables
//   triggerA/B/X/Q/Out     active-high load enables
//   aluOp[2:0]    ir[2:0]
//   halted        high in HALT
//
// Build option:
//   SEQUENCER_SINGLE_STEP_EN  adds the step input and the FETCH_WAIT state.
module bus_sequencer #(
    parameter int unsigned           PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          dbus,
    input  logic                flagZ,
`ifdef SEQUENCER_SINGLE_STEP_EN
    input  logic                step,
`endif
    output logic [PC_WIDTH-1:0] pc,
    output logic                assertBarRom,
    output logic                assertBarA,
    output logic                assertBarX,
    output logic                assertBarAlu,
    output logic                triggerA,
    output logic                triggerB,
    output logic                triggerX,
    output logic                triggerQ,
    output logic                triggerOut,
    output logic [2:0]          aluOp,
    output logic                halted
);

`ifdef SEQUENCER_SINGLE_STEP_EN
    typedef enum logic [1:0] {FETCH, EXEC, HALT, FETCH_WAIT} seqState_t;
    localparam seqState_t FETCH_ENTRY = FETCH_WAIT;
`else
    typedef enum logic [1:0] {FETCH, EXEC, HALT} seqState_t;
    localparam seqState_t FETCH_ENTRY = FETCH;
`endif

    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

    seqState_t         state;
    seqState_t         afterExec;
    logic [7:0]        ir;
    logic              srcImm;
    logic              jumpTaken;
    logic [PC_WIDTH-1:0] dbusPc;

    assign srcImm    = (ir[7:6] == 2'b11);
    assign jumpTaken = (ir[5:3] == 3'b100) || ((ir[5:3] == 3'b101) && flagZ);
    assign dbusPc    = PC_WIDTH'(dbus);

`ifdef SEQUENCER_SINGLE_STEP_EN
    // step sampled high at the end of EXEC goes straight to FETCH, so a
    // held step keeps the two-cycle instruction rate.
    assign afterExec = step ? FETCH : FETCH_WAIT;
`else
    assign afterExec = FETCH;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH_ENTRY;
            pc    <= RESET_PC;
            ir    <= '0;
        end else begin
            case (state)
`ifdef SEQUENCER_SINGLE_STEP_EN
                FETCH_WAIT: begin
                    if (step) state <= FETCH;
                end
`endif
                FETCH: begin
                    ir    <= dbus;
                    pc    <= pc + PC_ONE;
                    state <= (dbus == 8'hFF) ? HALT : EXEC;
                end
                EXEC: begin
                    // a taken jump wins over the immediate-operand increment
                    if (jumpTaken)
                        pc <= dbusPc;
                    else if (srcImm)
                        pc <= pc + PC_ONE;
                    state <= afterExec;
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= FETCH_ENTRY;
                end
            endcase
        end
    end

    always_comb begin
        assertBarRom = 1'b1;
        assertBarA   = 1'b1;
        assertBarX   = 1'b1;
        assertBarAlu = 1'b1;
        triggerA     = 1'b0;
        triggerB     = 1'b0;
        triggerX     = 1'b0;
        triggerQ     = 1'b0;
        triggerOut   = 1'b0;
        halted       = 1'b0;
        aluOp        = ir[2:0];
        if (!reset) begin
            case (state)
                FETCH: assertBarRom = 1'b0;
                EXEC: begin
                    case (ir[7:6])
                        2'b00:   assertBarA   = 1'b0;
                        2'b01:   assertBarX   = 1'b0;
                        2'b10:   assertBarAlu = 1'b0;
                        default: assertBarRom = 1'b0;
                    endcase
                    case (ir[5:3])
                        3'b000:  triggerA   = 1'b1;
                        3'b001:  triggerB   = 1'b1;
                        3'b010:  triggerX   = 1'b1;
                        3'b011:  triggerQ   = 1'b1;
                        3'b110:  triggerOut = 1'b1;
                        default: ;
                    endcase
                end
                HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
